tile_drawer: RTL and testbench

Downstream of the tile lookup stage. Takes one tile's base (x, y, colour) and paints the TILE_SIZE x TILE_SIZE square into the VGA adapter one pixel per clock. It then holds the tile lit for a programmable time and repaints it in ERASE_COLOUR. The game FSM steps the sequence counter on each done pulse, giving Simon-style flash-and-clear of each tile.

---
 rtl/tile_pkg.sv | 21 ++
 rtl/tile_scan_counter.sv | 31 +++
 rtl/tile_drawer.sv | 188 ++++++++++++++++++
 tb/tb_tile_drawer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared constants and FSM state encoding for the tile drawer.
package tile_pkg;

    localparam int TILE_SIZE_DEF = 8;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_BLUE  = 3'b001;
    localparam logic [2:0] COL_GREEN = 3'b010;
    localparam logic [2:0] COL_CYAN  = 3'b011;
    localparam logic [2:0] COL_RED   = 3'b100;
    localparam logic [2:0] COL_WHITE = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW,
        ST_HOLD,
        ST_ERASE,
        ST_DONE
    } tile_state_e;

endpackage

// File: rtl/tile_scan_counter.sv
// Row-major pixel offset counter shared by the draw and erase passes.
// Low half of the offset is the column, high half is the row.
module tile_scan_counter #(
    parameter  int TILE_SIZE = 8,
    localparam int OFF_W     = 2 * $clog2(TILE_SIZE)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [OFF_W-1:0] next_o,
    output logic             last_o
);

    logic [OFF_W-1:0] offset_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            offset_q <= '0;
        end else if (clr_i) begin
            offset_q <= '0;
        end else if (en_i) begin
            offset_q <= offset_q + OFF_W'(1);
        end
    end

    // TILE_SIZE is a power of two, so the final offset is all ones.
    assign next_o = offset_q + OFF_W'(1);
    assign last_o = &offset_q;

endmodule

// File: rtl/tile_drawer.sv
// Paints one tile pixel-per-clock, holds it lit for HOLD_CYCLES, then erases it.
// Define TILE_BORDER_EN to draw a white one-pixel border during the draw pass.
module tile_drawer
    import tile_pkg::*;
#(
    parameter int         TILE_SIZE    = TILE_SIZE_DEF,
    parameter int         HOLD_CYCLES  = 25000000,
    parameter logic [2:0] ERASE_COLOUR = COL_BLACK
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x_base,
    input  logic [6:0] y_base,
    input  logic [2:0] colour_in,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int LOG2   = $clog2(TILE_SIZE);
    localparam int OFF_W  = 2 * LOG2;
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);

`ifdef TILE_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif

    tile_state_e      state_q;
    logic [7:0]       x_lat_q;
    logic [6:0]       y_lat_q;
    logic [2:0]       col_lat_q;
    logic [HOLD_W-1:0] hold_q;
    logic [7:0]       vga_x_q;
    logic [6:0]       vga_y_q;
    logic [2:0]       vga_col_q;
    logic             plot_q;
    logic             busy_q;
    logic             done_q;

    logic             scan_clr_d;
    logic             scan_en_d;
    logic [OFF_W-1:0] scan_next;
    logic             scan_last;

    function automatic logic [7:0] pix_x(input logic [7:0] base, input logic [OFF_W-1:0] idx);
        return base + 8'(idx[LOG2-1:0]);
    endfunction

    function automatic logic [6:0] pix_y(input logic [6:0] base, input logic [OFF_W-1:0] idx);
        return base + 7'(idx[OFF_W-1:LOG2]);
    endfunction

    function automatic logic [2:0] draw_colour(input logic [2:0] base_col,
                                               input logic [OFF_W-1:0] idx);
        logic [LOG2-1:0] col;
        logic [LOG2-1:0] row;
        col = idx[LOG2-1:0];
        row = idx[OFF_W-1:LOG2];
        if (BORDER_EN && (col == '0 || col == '1 || row == '0 || row == '1)) begin
            return COL_WHITE;
        end
        return base_col;
    endfunction

    // Counter always points at the pixel currently on the outputs.
    always_comb begin
        scan_clr_d = 1'b0;
        scan_en_d  = 1'b0;
        case (state_q)
            ST_IDLE:  scan_clr_d = start;
            ST_DRAW: begin
                scan_en_d  = !scan_last;
                scan_clr_d = scan_last;
            end
            ST_HOLD:  scan_clr_d = (hold_q == HOLD_LAST);
            ST_ERASE: scan_en_d  = !scan_last;
            default: ;
        endcase
    end

    tile_scan_counter #(
        .TILE_SIZE(TILE_SIZE)
    ) u_scan (
        .clk_i (clock),
        .rst_ni(resetn),
        .clr_i (scan_clr_d),
        .en_i  (scan_en_d),
        .next_o(scan_next),
        .last_o(scan_last)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            x_lat_q   <= '0;
            y_lat_q   <= '0;
            col_lat_q <= '0;
            hold_q    <= '0;
            vga_x_q   <= '0;
            vga_y_q   <= '0;
            vga_col_q <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            plot_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_lat_q   <= x_base;
                        y_lat_q   <= y_base;
                        col_lat_q <= colour_in;
                        vga_x_q   <= x_base;
                        vga_y_q   <= y_base;
                        vga_col_q <= draw_colour(colour_in, OFF_W'(0));
                        plot_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (!scan_last) begin
                        vga_x_q   <= pix_x(x_lat_q, scan_next);
                        vga_y_q   <= pix_y(y_lat_q, scan_next);
                        vga_col_q <= draw_colour(col_lat_q, scan_next);
                        plot_q    <= 1'b1;
                    end else if (HOLD_CYCLES == 0) begin
                        vga_x_q   <= x_lat_q;
                        vga_y_q   <= y_lat_q;
                        vga_col_q <= ERASE_COLOUR;
                        plot_q    <= 1'b1;
                        state_q   <= ST_ERASE;
                    end else begin
                        hold_q  <= HOLD_W'(1);
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        vga_x_q   <= x_lat_q;
                        vga_y_q   <= y_lat_q;
                        vga_col_q <= ERASE_COLOUR;
                        plot_q    <= 1'b1;
                        hold_q    <= '0;
                        state_q   <= ST_ERASE;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                ST_ERASE: begin
                    if (!scan_last) begin
                        vga_x_q   <= pix_x(x_lat_q, scan_next);
                        vga_y_q   <= pix_y(y_lat_q, scan_next);
                        vga_col_q <= ERASE_COLOUR;
                        plot_q    <= 1'b1;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_col_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_tile_drawer.sv
// Scoreboard bench for tile_drawer: one instance with HOLD_CYCLES=4, one with HOLD_CYCLES=0.
module tb_tile_drawer;
    import tile_pkg::*;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

`ifdef TILE_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x_base = '0;
    logic [6:0] y_base = '0;
    logic [2:0] colour_in = '0;

    logic [7:0] vx_a, vx_b;
    logic [6:0] vy_a, vy_b;
    logic [2:0] vc_a, vc_b;
    logic       plot_a, plot_b, busy_a, busy_b, done_a, done_b;

    int   chk_cnt = 0;
    int   pass_cnt = 0;
    pix_t exp_a[$];
    pix_t exp_b[$];
    pix_t ea, eb;

    always #5 clock = ~clock;

    tile_drawer #(.TILE_SIZE(8), .HOLD_CYCLES(4), .ERASE_COLOUR(3'b000)) dut_a (
        .clock(clock), .resetn(resetn), .start(start),
        .x_base(x_base), .y_base(y_base), .colour_in(colour_in),
        .vga_x(vx_a), .vga_y(vy_a), .vga_colour(vc_a),
        .plot(plot_a), .busy(busy_a), .done(done_a)
    );

    tile_drawer #(.TILE_SIZE(8), .HOLD_CYCLES(0), .ERASE_COLOUR(3'b000)) dut_b (
        .clock(clock), .resetn(resetn), .start(start),
        .x_base(x_base), .y_base(y_base), .colour_in(colour_in),
        .vga_x(vx_b), .vga_y(vy_b), .vga_colour(vc_b),
        .plot(plot_b), .busy(busy_b), .done(done_b)
    );

    // Pixel scoreboards: every plot cycle pops the next expected pixel.
    always @(negedge clock) begin
        if (plot_a === 1'b1) begin
            chk_cnt++;
            if (exp_a.size() == 0) begin
                $display("FAIL pix_a: unexpected plot got (%0d,%0d,%b) want none", vx_a, vy_a, vc_a);
            end else begin
                ea = exp_a.pop_front();
                if ({vx_a, vy_a, vc_a} !== ea)
                    $display("FAIL pix_a: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                             vx_a, vy_a, vc_a, ea.x, ea.y, ea.c);
                else pass_cnt++;
            end
        end
        if (plot_b === 1'b1) begin
            chk_cnt++;
            if (exp_b.size() == 0) begin
                $display("FAIL pix_b: unexpected plot got (%0d,%0d,%b) want none", vx_b, vy_b, vc_b);
            end else begin
                eb = exp_b.pop_front();
                if ({vx_b, vy_b, vc_b} !== eb)
                    $display("FAIL pix_b: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                             vx_b, vy_b, vc_b, eb.x, eb.y, eb.c);
                else pass_cnt++;
            end
        end
    end

    // Reference model: row-major draw pass then erase pass, coordinates wrap.
    task automatic push_tile(input logic [7:0] xb, input logic [6:0] yb, input logic [2:0] c);
        pix_t p;
        for (int ph = 0; ph < 2; ph++)
            for (int r = 0; r < 8; r++)
                for (int k = 0; k < 8; k++) begin
                    p.x = 8'((int'(xb) + k) % 256);
                    p.y = 7'((int'(yb) + r) % 128);
                    if (ph == 1) p.c = 3'b000;
                    else if (BORDER && (r == 0 || r == 7 || k == 0 || k == 7)) p.c = 3'b111;
                    else p.c = c;
                    exp_a.push_back(p);
                    exp_b.push_back(p);
                end
    endtask

    task automatic drive_start(input logic [7:0] xb, input logic [6:0] yb, input logic [2:0] c);
        @(negedge clock);
        x_base = xb; y_base = yb; colour_in = c; start = 1'b1;
        push_tile(xb, yb, c);
    endtask

    task automatic test_reset();
        start = 1'b1;
        repeat (3) @(negedge clock);
        chk_cnt++;
        if ({vx_a, vy_a, vc_a, plot_a, busy_a, done_a} !== '0)
            $display("FAIL reset_a: got %h want 0", {vx_a, vy_a, vc_a, plot_a, busy_a, done_a});
        else pass_cnt++;
        chk_cnt++;
        if ({vx_b, vy_b, vc_b, plot_b, busy_b, done_b} !== '0)
            $display("FAIL reset_b: got %h want 0", {vx_b, vy_b, vc_b, plot_b, busy_b, done_b});
        else pass_cnt++;
        start = 1'b0;
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        chk_cnt++;
        if ({plot_a, busy_a, plot_b, busy_b} !== 4'b0000)
            $display("FAIL idle_after_reset: got %b want 0000", {plot_a, busy_a, plot_b, busy_b});
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [2:0] ce;
        logic       pa, da, ba, pb, db, bb;
        ce = BORDER ? 3'b111 : COL_GREEN;
        drive_start(8'd8, 7'd0, COL_GREEN);
        for (int n = 1; n <= 140; n++) begin
            @(negedge clock);
            if (n == 1) start = 1'b0;
            pa = (n <= 64) || (n >= 69 && n <= 132);
            da = (n == 133);
            ba = (n <= 133);
            pb = (n <= 128);
            db = (n == 129);
            bb = (n <= 129);
            chk_cnt++;
            if ({plot_a, done_a, busy_a} !== {pa, da, ba})
                $display("FAIL ctrl_a cycle %0d: plot/done/busy got %b want %b", n,
                         {plot_a, done_a, busy_a}, {pa, da, ba});
            else pass_cnt++;
            chk_cnt++;
            if ({plot_b, done_b, busy_b} !== {pb, db, bb})
                $display("FAIL ctrl_b cycle %0d: plot/done/busy got %b want %b", n,
                         {plot_b, done_b, busy_b}, {pb, db, bb});
            else pass_cnt++;
            if (n == 1 || n == 8 || n == 64 || n == 66 || n == 135) begin
                chk_cnt++;
                if (n == 1 && {vx_a, vy_a, vc_a} !== {8'd8, 7'd0, ce})
                    $display("FAIL first_pixel: got (%0d,%0d,%b) want (8,0,%b)", vx_a, vy_a, vc_a, ce);
                else if (n == 8 && {vx_a, vy_a, vc_a} !== {8'd15, 7'd0, ce})
                    $display("FAIL row0_end: got (%0d,%0d,%b) want (15,0,%b)", vx_a, vy_a, vc_a, ce);
                else if ((n == 64 || n == 66) && {vx_a, vy_a, vc_a} !== {8'd15, 7'd7, ce})
                    $display("FAIL last_draw_hold c%0d: got (%0d,%0d,%b) want (15,7,%b)", n, vx_a, vy_a, vc_a, ce);
                else if (n == 135 && {vx_a, vy_a, vc_a} !== {8'd15, 7'd7, 3'b000})
                    $display("FAIL idle_hold: got (%0d,%0d,%b) want (15,7,000)", vx_a, vy_a, vc_a);
                else pass_cnt++;
            end
            if (n == 65) begin
                chk_cnt++;
                if ({vx_b, vy_b, vc_b} !== {8'd8, 7'd0, 3'b000})
                    $display("FAIL hold0_erase_first: got (%0d,%0d,%b) want (8,0,000)", vx_b, vy_b, vc_b);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (exp_a.size() != 0 || exp_b.size() != 0)
            $display("FAIL basic_drain: left %0d/%0d want 0/0", exp_a.size(), exp_b.size());
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int  plots;
        bit  seen;
        plots = 0;
        seen = 1'b0;
        drive_start(8'd252, 7'd124, COL_CYAN);
        for (int n = 1; n <= 300 && !seen; n++) begin
            @(negedge clock);
            if (n == 1) start = 1'b0;
            if (plot_a) plots++;
            if (n == 5 || n == 64) begin
                chk_cnt++;
                if (n == 5 && {vx_a, vy_a} !== {8'd0, 7'd124})
                    $display("FAIL wrap_x: got (%0d,%0d) want (0,124)", vx_a, vy_a);
                else if (n == 64 && {vx_a, vy_a} !== {8'd3, 7'd3})
                    $display("FAIL wrap_xy: got (%0d,%0d) want (3,3)", vx_a, vy_a);
                else pass_cnt++;
            end
            if (done_a) seen = 1'b1;
        end
        chk_cnt++;
        if (!seen || plots != 128)
            $display("FAIL wrap_plots: done %0d plots %0d want 1 128", seen, plots);
        else pass_cnt++;
        @(negedge clock);
        chk_cnt++;
        if (exp_a.size() != 0 || exp_b.size() != 0)
            $display("FAIL wrap_drain: left %0d/%0d want 0/0", exp_a.size(), exp_b.size());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int   rise_a, rise_b;
        logic prev_a, prev_b;
        rise_a = 0; rise_b = 0;
        prev_a = busy_a; prev_b = busy_b;
        drive_start(8'd16, 7'd40, COL_BLUE);
        push_tile(8'd16, 7'd40, COL_BLUE);
        for (int n = 1; n <= 300; n++) begin
            @(negedge clock);
            if (busy_a && !prev_a) rise_a++;
            if (busy_b && !prev_b) rise_b++;
            prev_a = busy_a;
            prev_b = busy_b;
            if (n == 130 || n == 131 || n == 134 || n == 135) begin
                chk_cnt++;
                if (n == 134 && {busy_a, plot_a} !== 2'b00)
                    $display("FAIL b2b_gap_a: busy/plot got %b want 00", {busy_a, plot_a});
                else if (n == 135 && {busy_a, plot_a} !== 2'b11)
                    $display("FAIL b2b_restart_a: busy/plot got %b want 11", {busy_a, plot_a});
                else if (n == 130 && {busy_b, plot_b} !== 2'b00)
                    $display("FAIL b2b_gap_b: busy/plot got %b want 00", {busy_b, plot_b});
                else if (n == 131 && {busy_b, plot_b} !== 2'b11)
                    $display("FAIL b2b_restart_b: busy/plot got %b want 11", {busy_b, plot_b});
                else pass_cnt++;
            end
            if (n == 135) start = 1'b0;
        end
        chk_cnt++;
        if (rise_a != 2 || rise_b != 2)
            $display("FAIL b2b_starts: got %0d/%0d want 2/2", rise_a, rise_b);
        else pass_cnt++;
        chk_cnt++;
        if (exp_a.size() != 0 || exp_b.size() != 0 || busy_a || busy_b)
            $display("FAIL b2b_drain: left %0d/%0d busy %b want 0/0 00", exp_a.size(), exp_b.size(), {busy_a, busy_b});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_draw();
        drive_start(8'd40, 7'd20, COL_RED);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clock);
            if (n == 1) start = 1'b0;
        end
        chk_cnt++;
        if ({busy_a, plot_a} !== 2'b11)
            $display("FAIL mid_draw_active: busy/plot got %b want 11", {busy_a, plot_a});
        else pass_cnt++;
        #2 resetn = 1'b0;
        #1;
        chk_cnt++;
        if ({vx_a, vy_a, vc_a, plot_a, busy_a, done_a, vx_b, vy_b, vc_b, plot_b, busy_b, done_b} !== '0)
            $display("FAIL reset_abort: got %h want 0",
                     {vx_a, vy_a, vc_a, plot_a, busy_a, done_a, vx_b, vy_b, vc_b, plot_b, busy_b, done_b});
        else pass_cnt++;
        exp_a.delete();
        exp_b.delete();
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            chk_cnt++;
            if ({plot_a, busy_a, plot_b, busy_b} !== 4'b0000)
                $display("FAIL post_reset_idle c%0d: got %b want 0000", n, {plot_a, busy_a, plot_b, busy_b});
            else pass_cnt++;
        end
    endtask

    task automatic test_border();
        int whites, bodies, erased;
        bit seen;
        whites = 0; bodies = 0; erased = 0;
        seen = 1'b0;
        drive_start(8'd64, 7'd32, COL_RED);
        for (int n = 1; n <= 300 && !seen; n++) begin
            @(negedge clock);
            if (n == 1) start = 1'b0;
            if (plot_a && n <= 64) begin
                if (vc_a == 3'b111) whites++;
                if (vc_a == COL_RED) bodies++;
            end
            if (plot_a && n >= 69 && vc_a == 3'b000) erased++;
            if (done_a) seen = 1'b1;
        end
        chk_cnt++;
        if (whites != (BORDER ? 28 : 0) || bodies != (BORDER ? 36 : 64))
            $display("FAIL border_count: white %0d body %0d want %0d %0d",
                     whites, bodies, BORDER ? 28 : 0, BORDER ? 36 : 64);
        else pass_cnt++;
        chk_cnt++;
        if (!seen || erased != 64)
            $display("FAIL border_erase: done %0d erased %0d want 1 64", seen, erased);
        else pass_cnt++;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_reset_mid_draw();
        test_border();
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
